// File: rtl/iddr_gearbox_if.sv
// Pad-side DDR data, bitslip request and deserialized outputs of iddr_gearbox.
interface iddr_gearbox_if;
  logic       D;
  logic       CALIB;
  logic       Q0;
  logic       Q1;
  logic [3:0] Q;
  logic       QVALID;

  modport master (output D, CALIB, input Q0, Q1, Q, QVALID);
  modport slave  (input D, CALIB, output Q0, Q1, Q, QVALID);
endinterface

// File: rtl/iddr_gearbox.sv
// DDR input capture with 1:4 deserializer; bitslip via CALIB rising edge when
// IDDR_GEARBOX_BITSLIP_EN is defined, otherwise CALIB is ignored.
module iddr_gearbox #(
  parameter logic INIT = 1'b0
) (
  input  logic           CLK,
  input  logic           RESET,
  iddr_gearbox_if.slave  bus
);

  logic       r_rise;
  logic       r_fall;
  logic       r_q0;
  logic       r_q1;
  logic       r_cap_vld;
  logic       r_pair_vld;
  logic [3:0] r_acc;
  logic [1:0] r_cnt;
  logic [3:0] r_q;
  logic       r_qvalid;
  logic       w_slip;
  logic [3:0] w_acc_nxt;
  logic [1:0] w_cnt_nxt;
  logic [3:0] w_q_nxt;
  logic       w_valid_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_rise <= INIT;
    else       r_rise <= bus.D;
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) r_fall <= INIT;
    else       r_fall <= bus.D;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_q0 <= INIT;
      r_q1 <= INIT;
    end else begin
      r_q0 <= r_rise;
      r_q1 <= r_fall;
    end
  end

  // The first two pairs on Q0/Q1 after reset hold reset values, not stream bits.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cap_vld  <= 1'b0;
      r_pair_vld <= 1'b0;
    end else begin
      r_cap_vld  <= 1'b1;
      r_pair_vld <= r_cap_vld;
    end
  end

`ifdef IDDR_GEARBOX_BITSLIP_EN
  logic r_calib_d;
  logic r_slip;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_calib_d <= 1'b0;
      r_slip    <= 1'b0;
    end else begin
      r_calib_d <= bus.CALIB;
      r_slip    <= bus.CALIB & ~r_calib_d;
    end
  end

  assign w_slip = r_slip;
`else
  logic w_unused_calib;

  assign w_unused_calib = bus.CALIB;
  assign w_slip         = 1'b0;
`endif

  // Q0 then Q1 each land at the current fill position; the count wraps on the
  // 4th bit so a leftover Q1 bit starts the next word at position 0.
  always_comb begin
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_valid_nxt = 1'b0;
    if (r_pair_vld) begin
      if (!w_slip) begin
        w_acc_nxt[w_cnt_nxt] = r_q0;
        if (w_cnt_nxt == 2'd3) begin
          w_q_nxt     = w_acc_nxt;
          w_valid_nxt = 1'b1;
        end
        w_cnt_nxt = w_cnt_nxt + 2'd1;
      end
      w_acc_nxt[w_cnt_nxt] = r_q1;
      if (w_cnt_nxt == 2'd3) begin
        w_q_nxt     = w_acc_nxt;
        w_valid_nxt = 1'b1;
      end
      w_cnt_nxt = w_cnt_nxt + 2'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_q      <= {4{INIT}};
      r_qvalid <= 1'b0;
    end else begin
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_q      <= w_q_nxt;
      r_qvalid <= w_valid_nxt;
    end
  end

  assign bus.Q0     = r_q0;
  assign bus.Q1     = r_q1;
  assign bus.Q      = r_q;
  assign bus.QVALID = r_qvalid;

endmodule

// File: tb/tb_iddr_gearbox.sv
// Bench for iddr_gearbox: INIT=0 and INIT=1 instances share one stream and one
// bit-queue model; directed literals pin the model at key cycles.
module tb_iddr_gearbox;

`ifdef IDDR_GEARBOX_BITSLIP_EN
  localparam bit SLIP_EN = 1'b1;
`else
  localparam bit SLIP_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic d     = 1'b0;
  logic calib = 1'b0;

  always #5 clk = ~clk;

  iddr_gearbox_if if0 ();
  iddr_gearbox_if if1 ();

  assign if0.D     = d;
  assign if0.CALIB = calib;
  assign if1.D     = d;
  assign if1.CALIB = calib;

  iddr_gearbox #(.INIT(1'b0)) dut0 (.CLK(clk), .RESET(rst), .bus(if0));
  iddr_gearbox #(.INIT(1'b1)) dut1 (.CLK(clk), .RESET(rst), .bus(if1));

  bit         b   [0:255];
  bit         cal [0:127];
  int         checks   = 0;
  int         failures = 0;
  bit         active   = 1'b0;
  int         vcount   = 0;
  int         dc       = 0;
  bit         kept [$];
  logic [3:0] exp_q0;
  logic [3:0] exp_q1;
  logic       exp_v;
  int         p  = 0;
  int         mj = 0;
  int         v0 = 0;
  int         nslip = 0;

  task automatic chk(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  // Bit index j is lost when a CALIB edge seen at posedge j/2+1 selects it.
  function automatic bit dropped(input int j);
    int m;
    if (!SLIP_EN || (j % 2) != 0) return 1'b0;
    m = j / 2 + 1;
    return cal[m] && !cal[m-1];
  endfunction

  always @(negedge clk) begin
    if (!active) begin
      p      = 0;
      kept.delete();
      exp_q0 = 4'b0000;
      exp_q1 = 4'b1111;
      exp_v  = 1'b0;
    end else begin
      exp_v = 1'b0;
      if (p >= 2) begin
        for (int i = 0; i < 2; i++) begin
          mj = 2 * (p - 2) + i;
          if (!dropped(mj)) begin
            kept.push_back(b[mj]);
            if (kept.size() == 4) begin
              exp_q0 = {kept[3], kept[2], kept[1], kept[0]};
              exp_q1 = exp_q0;
              exp_v  = 1'b1;
              kept.delete();
            end
          end
        end
      end
      chk("qvalid_init0", p, {3'b000, if0.QVALID}, {3'b000, exp_v});
      chk("qvalid_init1", p, {3'b000, if1.QVALID}, {3'b000, exp_v});
      chk("word_init0",   p, if0.Q, exp_q0);
      chk("word_init1",   p, if1.Q, exp_q1);
      if (p >= 1) begin
        chk("q0_init0", p, {3'b000, if0.Q0}, {3'b000, b[2*p-2]});
        chk("q1_init0", p, {3'b000, if0.Q1}, {3'b000, b[2*p-1]});
        chk("q0_init1", p, {3'b000, if1.Q0}, {3'b000, b[2*p-2]});
        chk("q1_init1", p, {3'b000, if1.Q1}, {3'b000, b[2*p-1]});
      end
      if (if0.QVALID) vcount++;
      p++;
    end
  end

  task automatic start_test();
    active = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    dc     = 0;
    d      = b[0];
    calib  = cal[0];
    rst    = 1'b0;
    active = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
      d = b[2*dc+1];
      @(negedge clk);
      #2;
      dc++;
      d     = b[2*dc];
      calib = cal[dc];
    end
  endtask

  task automatic reset_now();
    active = 1'b0;
    rst    = 1'b1;
    #1;
  endtask

  task automatic fill_1000();
    for (int j = 0; j < 256; j++) b[j] = ((j % 4) == 0);
    for (int m = 0; m < 128; m++) cal[m] = 1'b0;
  endtask

  task automatic fill_pattern();
    for (int j = 0; j < 256; j++) b[j] = (((j * 7 + 3) % 5) < 2);
    b[10] = 1'b1;
    b[11] = 1'b0;
    for (int m = 0; m < 128; m++) cal[m] = 1'b0;
  endtask

  initial begin
    // Pair capture, then asynchronous reset between edges.
    fill_pattern();
    start_test();
    run_cycles(7);
    chk("pair_rise_c6", 6, {3'b000, if0.Q0}, 4'b0001);
    chk("pair_fall_c6", 6, {3'b000, if0.Q1}, 4'b0000);
    run_cycles(9);
    reset_now();
    chk("rst_q0_init0",     0, {3'b000, if0.Q0},     4'b0000);
    chk("rst_q1_init0",     0, {3'b000, if0.Q1},     4'b0000);
    chk("rst_word_init0",   0, if0.Q,                4'b0000);
    chk("rst_qvalid_init0", 0, {3'b000, if0.QVALID}, 4'b0000);
    chk("rst_q0_init1",     0, {3'b000, if1.Q0},     4'b0001);
    chk("rst_q1_init1",     0, {3'b000, if1.Q1},     4'b0001);
    chk("rst_word_init1",   0, if1.Q,                4'b1111);
    chk("rst_qvalid_init1", 0, {3'b000, if1.QVALID}, 4'b0000);

    // Word assembly without slips.
    fill_1000();
    v0 = vcount;
    start_test();
    run_cycles(4);
    chk("first_valid_c3", 3, {3'b000, if0.QVALID}, 4'b0001);
    chk("first_word_c3",  3, if0.Q, 4'b0001);
    chk("first_word1_c3", 3, if1.Q, 4'b0001);
    run_cycles(36);
    nslip = vcount - v0;
    chk("pulses_noslip", 39, nslip[3:0], 4'd3);
    chk("pulses_noslip_hi", 39, {nslip[7:4]}, 4'd1);

    // Mid-word reset, then single slip (CALIB held) and a second slip.
    fill_1000();
    for (int m = 6; m <= 9; m++) cal[m] = 1'b1;
    cal[20] = 1'b1;
    cal[21] = 1'b1;
    start_test();
    run_cycles(5);
    reset_now();
    chk("midrst_qvalid", 4, {3'b000, if0.QVALID}, 4'b0000);
    chk("midrst_word",   4, if0.Q, 4'b0000);
    start_test();
    run_cycles(3);
    chk("after_rst_c2_novalid", 2, {3'b000, if0.QVALID}, 4'b0000);
    run_cycles(1);
    chk("after_rst_c3_valid", 3, {3'b000, if0.QVALID}, 4'b0001);
    chk("after_rst_c3_word",  3, if0.Q, 4'b0001);
    run_cycles(14);
    chk("one_slip_word",  17, if0.Q, SLIP_EN ? 4'b1000 : 4'b0001);
    run_cycles(14);
    chk("two_slip_word",  31, if0.Q, SLIP_EN ? 4'b0100 : 4'b0001);

    // Four slips spaced 4 cycles apart skip exactly one word.
    fill_1000();
    cal[6]  = 1'b1;
    cal[10] = 1'b1;
    cal[14] = 1'b1;
    cal[18] = 1'b1;
    v0 = vcount;
    start_test();
    run_cycles(40);
    chk("four_slip_pulses", 39, 4'(vcount - v0), 4'(nslip - (SLIP_EN ? 1 : 0)));
    chk("four_slip_word",   39, if0.Q, 4'b0001);

    active = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
